// File: rtl/stage_4_datapath.sv
`default_nettype none
// ============================================================================
// Module      : stage_4_datapath
// Description : Multi-cycle 16-bit memory-to-memory processor datapath.
//               PC, Op, A, B, Dest and ALUOut registers, a 256x16 unified
//               memory with asynchronous read, and a 16-bit ALU. The datapath
//               is steered cycle by cycle through external select and
//               write-enable inputs.
//               Optional feature macro: STAGE_4_COND_BRANCH_EN
//               (conditional PC load on isTrue when normOrBranch=1).
// Revision    : 1.0 - initial release
// ============================================================================
module stage_4_datapath (
    input  logic        CLK,
    input  logic        reset,
    input  logic        inputPC,
    input  logic        normOrBranch,
    input  logic        WEpc,
    input  logic        writeMem,
    input  logic        regOrPC,
    input  logic [1:0]  memAddr,
    input  logic [1:0]  memWriteData,
    input  logic        valA,
    input  logic [1:0]  ALUsrca,
    input  logic [1:0]  ALUsrcb,
    input  logic [3:0]  ALUOp,
    input  logic        writeA,
    input  logic        writeB,
    input  logic        writeDest,
    input  logic        writeOp,
    input  logic [15:0] ALUsrcA2,
    input  logic [15:0] MA3,
    output logic [15:0] ALUoutVal,
    output logic        isTrue,
    output logic [7:0]  PCout,
    output logic [15:0] Aout,
    output logic [15:0] Bout,
    output logic [15:0] Destout,
    output logic [7:0]  Opout,
    output logic [15:0] MemOut
);

    // ALU function codes
    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_OR  = 4'b0010;
    localparam logic [3:0] c_OP_AND = 4'b0011;
    localparam logic [3:0] c_OP_XOR = 4'b0100;
    localparam logic [3:0] c_OP_SHL = 4'b0101;
    localparam logic [3:0] c_OP_SHR = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;

    // Architectural registers
    logic [7:0]  r_pc;
    logic [7:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_dest;
    logic [15:0] r_aluout;

    // Unified memory with its power-up image; contents survive reset
    logic [15:0] r_mem [0:255] = '{
        0       : 16'h0000,
        1       : 16'd13,
        2       : 16'd14,
        3       : 16'd16,
        13      : 16'd10,
        14      : 16'd5,
        default : 16'h0000
    };

    logic [7:0]  w_mem_addr;
    logic [15:0] w_mem_wdata;
    logic [15:0] w_alu_a;
    logic [15:0] w_alu_b;
    logic [15:0] w_alu_y;
    logic [7:0]  w_pc_inc;
    logic [7:0]  w_pc_next;
    logic [15:0] w_a_next;
    logic        w_unused;

    // Upper address bits of MA3 are not used; normOrBranch only matters
    // when conditional branching is built in
    assign w_unused = ^{MA3[15:8], normOrBranch};

    // Memory address select: PC, or one of A/B/Dest/MA3 (low byte)
    always_comb begin
        w_mem_addr = r_pc;
        if (regOrPC) begin
            case (memAddr)
                2'b00:   w_mem_addr = r_a[7:0];
                2'b01:   w_mem_addr = r_b[7:0];
                2'b10:   w_mem_addr = r_dest[7:0];
                default: w_mem_addr = MA3[7:0];
            endcase
        end
    end

    // Memory write-data select; PC is zero-extended
    always_comb begin
        case (memWriteData)
            2'b00:   w_mem_wdata = r_a;
            2'b01:   w_mem_wdata = r_aluout;
            2'b10:   w_mem_wdata = r_b;
            default: w_mem_wdata = {8'h00, r_pc};
        endcase
    end

    // Asynchronous memory read at the selected address
    assign MemOut = r_mem[w_mem_addr];

    // Memory write port; a reset cycle suppresses the write
    always_ff @(posedge CLK) begin
        if (!reset && writeMem) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // ALU operand selects; PC and Op are zero-extended
    always_comb begin
        case (ALUsrca)
            2'b00:   w_alu_a = r_a;
            2'b01:   w_alu_a = {8'h00, r_pc};
            2'b10:   w_alu_a = ALUsrcA2;
            default: w_alu_a = MemOut;
        endcase
        case (ALUsrcb)
            2'b00:   w_alu_b = r_b;
            2'b01:   w_alu_b = 16'd1;
            2'b10:   w_alu_b = {8'h00, r_op};
            default: w_alu_b = MemOut;
        endcase
    end

    // ALU: modulo-2^16 arithmetic, logic, 4-bit shifts, signed set-less-than
    always_comb begin
        w_alu_y = w_alu_a;
        case (ALUOp)
            c_OP_ADD: w_alu_y = w_alu_a + w_alu_b;
            c_OP_SUB: w_alu_y = w_alu_a - w_alu_b;
            c_OP_OR:  w_alu_y = w_alu_a | w_alu_b;
            c_OP_AND: w_alu_y = w_alu_a & w_alu_b;
            c_OP_XOR: w_alu_y = w_alu_a ^ w_alu_b;
            c_OP_SHL: w_alu_y = w_alu_a << w_alu_b[3:0];
            c_OP_SHR: w_alu_y = w_alu_a >> w_alu_b[3:0];
            c_OP_SLT: w_alu_y = ($signed(w_alu_a) < $signed(w_alu_b)) ? 16'd1 : 16'd0;
            default:  w_alu_y = w_alu_a;
        endcase
    end

    assign ALUoutVal = w_alu_y;
    assign isTrue    = (w_alu_y == 16'h0000);

    // Dedicated PC incrementer, wraps 255 -> 0 naturally
    assign w_pc_inc = r_pc + 8'd1;

    // PC next-value select (optionally conditional on isTrue)
    always_comb begin
        w_pc_next = w_pc_inc;
        if (inputPC) begin
`ifdef STAGE_4_COND_BRANCH_EN
            if (normOrBranch && !isTrue) begin
                w_pc_next = w_pc_inc;
            end else begin
                w_pc_next = w_alu_y[7:0];
            end
`else
            w_pc_next = w_alu_y[7:0];
`endif
        end
    end

    // A source: memory read or ALU result
    assign w_a_next = valA ? w_alu_y : MemOut;

    // Register file update; reset clears all registers and blocks loads
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pc     <= 8'h00;
            r_op     <= 8'h00;
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_dest   <= 16'h0000;
            r_aluout <= 16'h0000;
        end else begin
            r_aluout <= w_alu_y;
            if (WEpc)      r_pc   <= w_pc_next;
            if (writeOp)   r_op   <= MemOut[7:0];
            if (writeA)    r_a    <= w_a_next;
            if (writeB)    r_b    <= MemOut;
            if (writeDest) r_dest <= MemOut;
        end
    end

    assign PCout   = r_pc;
    assign Opout   = r_op;
    assign Aout    = r_a;
    assign Bout    = r_b;
    assign Destout = r_dest;

endmodule
`default_nettype wire

// File: tb/tb_stage_4_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_4_datapath
// Description : Scoreboard bench for stage_4_datapath. Stimulus pushes the
//               expected outputs for the coming edge; a monitor pops and
//               compares them on the falling edge after it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_4_datapath;

    logic        CLK = 1'b0;
    logic        reset, inputPC, normOrBranch, WEpc, writeMem, regOrPC;
    logic [1:0]  memAddr, memWriteData, ALUsrca, ALUsrcb;
    logic        valA;
    logic [3:0]  ALUOp;
    logic        writeA, writeB, writeDest, writeOp;
    logic [15:0] ALUsrcA2, MA3;
    logic [15:0] ALUoutVal, Aout, Bout, Destout, MemOut;
    logic        isTrue;
    logic [7:0]  PCout, Opout;

    always #5 CLK = ~CLK;

    stage_4_datapath dut (
        .CLK(CLK), .reset(reset), .inputPC(inputPC), .normOrBranch(normOrBranch),
        .WEpc(WEpc), .writeMem(writeMem), .regOrPC(regOrPC), .memAddr(memAddr),
        .memWriteData(memWriteData), .valA(valA), .ALUsrca(ALUsrca), .ALUsrcb(ALUsrcb),
        .ALUOp(ALUOp), .writeA(writeA), .writeB(writeB), .writeDest(writeDest),
        .writeOp(writeOp), .ALUsrcA2(ALUsrcA2), .MA3(MA3), .ALUoutVal(ALUoutVal),
        .isTrue(isTrue), .PCout(PCout), .Aout(Aout), .Bout(Bout), .Destout(Destout),
        .Opout(Opout), .MemOut(MemOut)
    );

    // Observable selector codes
    localparam int c_PC = 0, c_A = 1, c_B = 2, c_DEST = 3, c_OP = 4, c_MEM = 5, c_TRUE = 6;

    typedef struct {
        int          sig;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] mdl_mem [256];

    // Monitor: everything queued before an edge is checked after it
    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.sig)
                c_PC:    act = {8'h00, PCout};
                c_A:     act = Aout;
                c_B:     act = Bout;
                c_DEST:  act = Destout;
                c_OP:    act = {8'h00, Opout};
                c_MEM:   act = MemOut;
                default: act = {15'h0, isTrue};
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    // Behavioural ALU from the function table
    function automatic logic [15:0] alu_ref(logic [3:0] op, logic [15:0] a, logic [15:0] b);
        int sa, sbv;
        sa  = $signed(a);
        sbv = $signed(b);
        case (op)
            4'd0:    return 16'((int'(a) + int'(b)) % 65536);
            4'd1:    return 16'((int'(a) - int'(b) + 65536) % 65536);
            4'd2:    return a | b;
            4'd3:    return a & b;
            4'd4:    return a ^ b;
            4'd5:    return 16'((int'(a) * (1 << int'(b[3:0]))) % 65536);
            4'd6:    return 16'(int'(a) / (1 << int'(b[3:0])));
            4'd7:    return (sa < sbv) ? 16'd1 : 16'd0;
            default: return a;
        endcase
    endfunction

    task automatic exp_push(int sig, logic [15:0] v, string n);
        exp_t e;
        e.sig = sig; e.exp = v; e.name = n;
        sb.push_back(e);
    endtask

    // Drive one rising edge; inputs change only after the monitor sampled
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic idle();
        reset = 0; inputPC = 0; normOrBranch = 0; WEpc = 0; writeMem = 0;
        regOrPC = 0; memAddr = 2'b00; memWriteData = 2'b00; valA = 0;
        ALUsrca = 2'b00; ALUsrcb = 2'b00; ALUOp = 4'h0;
        writeA = 0; writeB = 0; writeDest = 0; writeOp = 0;
        ALUsrcA2 = 16'h0; MA3 = 16'h0;
    endtask

    // Write an arbitrary word: pass it through the ALU, then store ALUOut
    task automatic poke(logic [7:0] addr, logic [15:0] val);
        idle(); ALUsrca = 2'b10; ALUsrcA2 = val; ALUOp = 4'hF;
        tick();
        idle(); writeMem = 1; regOrPC = 1; memAddr = 2'b11; MA3 = {8'h00, addr};
        memWriteData = 2'b01;
        tick();
        mdl_mem[addr] = val;
    endtask

    // Full instruction from reset; imm=1 skips the second operand fetch
    task automatic run_instr(logic [3:0] op, bit imm, string tag);
        logic [15:0] pa, pb, pd, va, vb, res;
        pa  = mdl_mem[1];
        pb  = mdl_mem[2];
        pd  = mdl_mem[3];
        va  = mdl_mem[pa[7:0]];
        vb  = imm ? pb : mdl_mem[pb[7:0]];
        res = alu_ref(op, va, vb);

        idle(); reset = 1;
        tick();
        idle(); writeOp = 1; WEpc = 1;
        exp_push(c_OP, {8'h00, mdl_mem[0][7:0]}, {tag, "_op"});
        tick();
        idle(); writeA = 1; WEpc = 1;
        tick();
        idle(); writeB = 1; WEpc = 1;
        exp_push(c_B, pb, {tag, "_bfetch"});
        tick();
        idle(); regOrPC = 1; memAddr = 2'b00; writeA = 1;
        exp_push(c_A, va, {tag, "_aval"});
        tick();
        if (!imm) begin
            idle(); regOrPC = 1; memAddr = 2'b01; writeB = 1;
            exp_push(c_B, vb, {tag, "_bval"});
            tick();
        end
        idle(); ALUOp = op; writeDest = 1;
        exp_push(c_DEST, pd, {tag, "_dest"});
        tick();
        idle(); writeMem = 1; regOrPC = 1; memAddr = 2'b10; memWriteData = 2'b01;
        WEpc = 1; ALUOp = op;
        mdl_mem[pd[7:0]] = res;
        exp_push(c_MEM, res, {tag, "_result"});
        exp_push(c_PC, 16'd4, {tag, "_pc"});
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  ra, rb, rd;
        logic [15:0] pc_exp;
        for (int i = 0; i < 256; i++) mdl_mem[i] = 16'h0000;
        mdl_mem[1] = 16'd13; mdl_mem[2] = 16'd14; mdl_mem[3] = 16'd16;
        mdl_mem[13] = 16'd10; mdl_mem[14] = 16'd5;
        idle();
        #1;

        // Reset state
        reset = 1;
        exp_push(c_PC, 16'h0, "rst_pc");
        exp_push(c_A, 16'h0, "rst_a");
        exp_push(c_B, 16'h0, "rst_b");
        exp_push(c_DEST, 16'h0, "rst_dest");
        exp_push(c_OP, 16'h0, "rst_op");
        tick();

        // Directed instructions on the power-up program
        run_instr(4'h0, 1'b0, "add");
        run_instr(4'h1, 1'b0, "sub");
        run_instr(4'h3, 1'b0, "and");
        run_instr(4'h2, 1'b0, "or");
        run_instr(4'h0, 1'b1, "imm_add");

        // Reset with a pending memory write: write and loads are dropped
        idle(); reset = 1; writeMem = 1; regOrPC = 1; memAddr = 2'b11; MA3 = 16'd16;
        memWriteData = 2'b11; ALUsrca = 2'b10; ALUsrcA2 = 16'h1234; ALUOp = 4'hF;
        writeA = 1; writeB = 1; writeDest = 1; writeOp = 1; WEpc = 1;
        exp_push(c_MEM, mdl_mem[16], "rstw_mem");
        exp_push(c_PC, 16'h0, "rstw_pc");
        exp_push(c_A, 16'h0, "rstw_a");
        exp_push(c_B, 16'h0, "rstw_b");
        exp_push(c_DEST, 16'h0, "rstw_dest");
        exp_push(c_OP, 16'h0, "rstw_op");
        tick();
        // ALUOut was cleared by reset: storing it now writes zero
        idle(); writeMem = 1; regOrPC = 1; memAddr = 2'b11; MA3 = 16'd200;
        memWriteData = 2'b01;
        mdl_mem[200] = 16'h0000;
        exp_push(c_MEM, 16'h0000, "rst_aluout");
        tick();

        // PC via ALU wraps 255 -> 0
        idle(); ALUsrca = 2'b10; ALUsrcA2 = 16'h00FF; ALUOp = 4'hF; inputPC = 1; WEpc = 1;
        exp_push(c_PC, 16'h00FF, "pc_load255");
        tick();
        idle(); ALUsrca = 2'b01; ALUsrcb = 2'b01; ALUOp = 4'h0; inputPC = 1; WEpc = 1;
        exp_push(c_PC, 16'h0000, "pc_alu_wrap");
        tick();
        // PC incrementer wraps 255 -> 0
        idle(); ALUsrca = 2'b10; ALUsrcA2 = 16'h00FF; ALUOp = 4'hF; inputPC = 1; WEpc = 1;
        tick();
        idle(); WEpc = 1;
        exp_push(c_PC, 16'h0000, "pc_inc_wrap");
        tick();
        // WEpc=0 holds PC
        idle(); inputPC = 1; ALUsrca = 2'b10; ALUsrcA2 = 16'h0077; ALUOp = 4'hF;
        exp_push(c_PC, 16'h0000, "pc_hold");
        tick();
        // Branch request with isTrue=0
        idle(); ALUsrca = 2'b10; ALUsrcA2 = 16'h0040; ALUOp = 4'hF; inputPC = 1;
        normOrBranch = 1; WEpc = 1;
`ifdef STAGE_4_COND_BRANCH_EN
        pc_exp = 16'h0001;
`else
        pc_exp = 16'h0040;
`endif
        exp_push(c_TRUE, 16'h0, "br_istrue0");
        exp_push(c_PC, pc_exp, "br_not_taken");
        tick();
        // Branch request with isTrue=1 loads the ALU value either way
        idle(); ALUsrca = 2'b10; ALUsrcA2 = 16'h0000; ALUOp = 4'hF; inputPC = 1;
        normOrBranch = 1; WEpc = 1;
        exp_push(c_TRUE, 16'h1, "br_istrue1");
        exp_push(c_PC, 16'h0000, "br_taken");
        tick();

        // Randomized programs and operands
        for (int n = 0; n < 14; n++) begin
            ra = 8'($urandom_range(20, 255));
            rb = 8'($urandom_range(20, 255));
            rd = 8'($urandom_range(20, 255));
            poke(8'd0, 16'($urandom));
            poke(8'd1, {8'($urandom), ra});
            poke(8'd2, {8'($urandom), rb});
            poke(8'd3, {8'($urandom), rd});
            poke(ra, 16'($urandom));
            if (ra != rb) poke(rb, 16'($urandom));
            run_instr(4'($urandom), bit'(n % 3 == 2), $sformatf("rnd%0d", n));
        end

        idle();
        tick();
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
